// File: rtl/c432_oracle_pkg.sv
// Shared types and constants for the c432 oracle query front-end.
package c432_oracle_pkg;
  localparam int N_IN_DEF  = 36;
  localparam int N_OUT_DEF = 7;
  localparam int TAG_W_DEF = 8;

  // x^7 + x + 1: feedback taps at bits 0 and 1
  localparam logic [6:0] MISR_POLY = 7'h03;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;
endpackage

// File: rtl/c432_misr.sv
// Response-folding MISR; clear is applied before the fold when both occur.
module c432_misr
  import c432_oracle_pkg::*;
#(
  parameter int             W    = N_OUT_DEF,
  parameter logic [W-1:0]   POLY = MISR_POLY
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] sig
);

  logic [W-1:0] base;
  logic [W-1:0] fold;

  always_comb begin
    base = clear ? '0 : sig;
    fold = {base[W-2:0], 1'b0} ^ (base[W-1] ? POLY : '0) ^ din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     sig <= '0;
    else if (en)    sig <= fold;
    else if (clear) sig <= '0;
  end

endmodule

// File: rtl/c432_oracle_seq.sv
// Query front-end: applies patterns to the c432 netlist, samples its response
// after a settle interval and returns it with the query tag.
module c432_oracle_seq
  import c432_oracle_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int N_OUT      = N_OUT_DEF,
  parameter int SETTLE_CYC = 2,
  parameter int TAG_W      = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [N_IN-1:0]   q_pattern,
  input  logic [TAG_W-1:0]  q_tag,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [N_OUT-1:0]  r_resp,
  output logic [TAG_W-1:0]  r_tag,
  input  logic              sig_clear,
  output logic [N_OUT-1:0]  sig,
  output logic [15:0]       q_count
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYC - 1);

  state_t           state, state_nxt;
  logic [3:0]       cnt;
  logic [TAG_W-1:0] tag_q;
  logic             accept;
  logic             capture;
  logic             handshake;

  always_comb begin
    state_nxt = state;
    q_ready   = 1'b0;
    case (state)
      IDLE: begin
        q_ready = 1'b1;
        if (q_valid) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        // back-to-back: a new query may enter in the same cycle as the handshake
        q_ready = r_ready;
        if (r_ready) state_nxt = q_valid ? SETTLE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = q_valid && q_ready;
  assign capture   = (state == SETTLE) && (cnt == 4'd0);
  assign handshake = (state == RESP) && r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      dut_in  <= '0;
      tag_q   <= '0;
      r_valid <= 1'b0;
      r_resp  <= '0;
      r_tag   <= '0;
      q_count <= 16'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dut_in <= q_pattern;
        tag_q  <= q_tag;
        cnt    <= CNT_LOAD;
      end else if (state == SETTLE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        r_resp  <= dut_out;
        r_tag   <= tag_q;
        r_valid <= 1'b1;
      end else if (handshake) begin
        r_valid <= 1'b0;
      end
      if (handshake && q_count != 16'hFFFF) q_count <= q_count + 16'd1;
    end
  end

  c432_misr #(.W(N_OUT), .POLY(N_OUT'(MISR_POLY))) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (sig_clear),
    .en    (capture),
    .din   (dut_out),
    .sig   (sig)
  );

endmodule
